// File: rtl/rename_reg_file_pkg.sv
// Shared widths and tag constants for the register rename file.
// Tag 16 marks a register whose value is architectural, not owned by a ROB entry.
package rename_reg_file_pkg;
  localparam int ROB_W    = 5;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << REG_W;

  localparam logic [ROB_W-1:0] INVALID_ROB = 5'd16;

  typedef logic [ROB_W-1:0]  rob_id_t;
  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register ROB ownership tags.
// Two zero-latency read ports, commit bypass, rename on issue, rollback flush.
module rename_reg_file
  import rename_reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  output logic [ROB_W-1:0]  Q1,
  output logic [ROB_W-1:0]  Q2,
  output logic [DATA_W-1:0] V1,
  output logic [DATA_W-1:0] V2,
  input  logic              issue_en,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [ROB_W-1:0]  issue_rob_id,
  input  logic              commit_en,
  input  logic [REG_W-1:0]  commit_rd,
  input  logic [ROB_W-1:0]  commit_rob_id,
  input  logic [DATA_W-1:0] commit_data,
  input  logic              rollback
);

  logic [DATA_W-1:0] r_val [NUM_REGS];
  logic [ROB_W-1:0]  r_tag [NUM_REGS];

  logic              w_issue_wr;
  logic              w_commit_wr;
  logic              w_commit_clr;
  logic              w_commit_live;
  logic [ROB_W-1:0]  w_tag1;
  logic [ROB_W-1:0]  w_tag2;

  assign w_issue_wr    = issue_en && !rollback && (issue_rd != '0);
  assign w_commit_wr   = commit_en && (commit_rd != '0);
  // A rename of the same register on this edge takes ownership, so keep its tag.
  assign w_commit_clr  = w_commit_wr && (r_tag[commit_rd] == commit_rob_id) &&
                         !(w_issue_wr && (issue_rd == commit_rd));
  assign w_commit_live = commit_en && (commit_rob_id != INVALID_ROB);

  assign w_tag1 = r_tag[rs1];
  assign w_tag2 = r_tag[rs2];

  always_comb begin
    Q1 = w_tag1;
    V1 = r_val[rs1];
    if (rs1 == '0) begin
      Q1 = INVALID_ROB;
      V1 = '0;
    end else if (w_commit_live && (w_tag1 == commit_rob_id)) begin
      Q1 = INVALID_ROB;
      V1 = commit_data;
    end
  end

  always_comb begin
    Q2 = w_tag2;
    V2 = r_val[rs2];
    if (rs2 == '0) begin
      Q2 = INVALID_ROB;
      V2 = '0;
    end else if (w_commit_live && (w_tag2 == commit_rob_id)) begin
      Q2 = INVALID_ROB;
      V2 = commit_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= INVALID_ROB;
      end
    end else if (rdy) begin
      if (w_commit_wr) r_val[commit_rd] <= commit_data;
      if (rollback) begin
        for (int i = 0; i < NUM_REGS; i++) r_tag[i] <= INVALID_ROB;
      end else begin
        if (w_commit_clr) r_tag[commit_rd] <= INVALID_ROB;
        if (w_issue_wr)   r_tag[issue_rd]  <= issue_rob_id;
      end
    end
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed-vector bench for rename_reg_file with hand-computed expectations.
module tb_rename_reg_file;
  import rename_reg_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [4:0]  rs1, rs2;
  logic [4:0]  Q1, Q2;
  logic [31:0] V1, V2;
  logic        issue_en;
  logic [4:0]  issue_rd, issue_rob_id;
  logic        commit_en;
  logic [4:0]  commit_rd, commit_rob_id;
  logic [31:0] commit_data;
  logic        rollback;

  int n_vec = 0;
  int n_err = 0;

  rename_reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rs1(rs1), .rs2(rs2), .Q1(Q1), .Q2(Q2), .V1(V1), .V2(V2),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
    .commit_data(commit_data), .rollback(rollback)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 1'b0; commit_en = 1'b0; rollback = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] id);
    issue_en = 1'b1; issue_rd = rd; issue_rob_id = id;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [4:0] id, input logic [31:0] d);
    commit_en = 1'b1; commit_rd = rd; commit_rob_id = id; commit_data = d;
  endtask

  task automatic rd1(input logic [4:0] r);
    rs1 = r;
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    issue_rd = 5'd0; issue_rob_id = 5'd0; commit_rd = 5'd0;
    commit_rob_id = 5'd0; commit_data = 32'd0;
    idle();
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Reset state
    rd1(5'd5);
    chk("rst_q1", 32'(Q1), 32'd16);
    chk("rst_v1", V1, 32'd0);

    // Rename then commit, including same-cycle bypass
    issue(5'd3, 5'd7); tick(); idle();
    rd1(5'd3);
    chk("ren_q1", 32'(Q1), 32'd7);
    commit(5'd3, 5'd7, 32'hDEAD); #1;
    chk("ren_byp_q1", 32'(Q1), 32'd16);
    chk("ren_byp_v1", V1, 32'hDEAD);
    tick(); idle(); #1;
    chk("cmt_q1", 32'(Q1), 32'd16);
    chk("cmt_v1", V1, 32'hDEAD);

    // Stale commit: value lands, newer tag survives
    issue(5'd3, 5'd7); tick();
    issue(5'd3, 5'd9); tick(); idle();
    commit(5'd3, 5'd7, 32'd5); tick(); idle(); #1;
    chk("stale_q1", 32'(Q1), 32'd9);
    chk("stale_v1", V1, 32'd5);

    // Bypass on read port 2
    issue(5'd4, 5'd2); tick(); idle();
    rs2 = 5'd4; #1;
    chk("byp_pre_q2", 32'(Q2), 32'd2);
    commit(5'd4, 5'd2, 32'h55); #1;
    chk("byp_q2", 32'(Q2), 32'd16);
    chk("byp_v2", V2, 32'h55);
    chk("byp_q1_other", 32'(Q1), 32'd9);
    tick(); idle(); #1;
    chk("byp_post_q2", 32'(Q2), 32'd16);
    chk("byp_post_v2", V2, 32'h55);

    // Register 0 ignores writes
    issue(5'd0, 5'd5); commit(5'd0, 5'd1, 32'h123); tick(); idle();
    rd1(5'd0);
    chk("x0_q1", 32'(Q1), 32'd16);
    chk("x0_v1", V1, 32'd0);

    // Same-edge issue and commit on r6: issue tag wins, value updates
    issue(5'd6, 5'd11); tick(); idle();
    issue(5'd6, 5'd11); commit(5'd6, 5'd11, 32'h66); tick(); idle();
    rd1(5'd6);
    chk("conf_q1", 32'(Q1), 32'd11);
    chk("conf_v1", V1, 32'h66);
    issue(5'd6, 5'd12); commit(5'd6, 5'd11, 32'h67); tick(); idle(); #1;
    chk("conf2_q1", 32'(Q1), 32'd12);
    chk("conf2_v1", V1, 32'h67);

    // Rollback flushes all tags, drops issue, keeps commit value
    for (int r = 1; r <= 5; r++) begin
      issue(5'(r), 5'(r)); tick();
    end
    idle();
    rd1(5'd5);
    chk("rb_pre_q5", 32'(Q1), 32'd5);
    rollback = 1'b1; issue(5'd8, 5'd3); commit(5'd2, 5'd14, 32'h22);
    tick(); idle();
    for (int r = 1; r <= 5; r++) begin
      rd1(5'(r));
      chk($sformatf("rb_q_r%0d", r), 32'(Q1), 32'd16);
    end
    rd1(5'd8);
    chk("rb_q_r8", 32'(Q1), 32'd16);
    rd1(5'd2);
    chk("rb_v_r2", V1, 32'h22);

    // rdy=0 freezes state but reads stay live
    rdy = 1'b0; issue(5'd9, 5'd4); commit(5'd9, 5'd4, 32'h99);
    rd1(5'd2);
    chk("frz_live_v1", V1, 32'h22);
    tick(); idle(); rdy = 1'b1;
    rd1(5'd9);
    chk("frz_q1", 32'(Q1), 32'd16);
    chk("frz_v1", V1, 32'd0);

    // Reset mid-operation discards that edge's rename and commit
    issue(5'd10, 5'd5); tick(); idle();
    rd1(5'd10);
    chk("mid_pre_q1", 32'(Q1), 32'd5);
    rst = 1'b1; rdy = 1'b0;
    issue(5'd11, 5'd6); commit(5'd10, 5'd5, 32'hAA);
    tick(); idle(); rst = 1'b0; rdy = 1'b1;
    rd1(5'd10);
    chk("mid_q1", 32'(Q1), 32'd16);
    chk("mid_v1", V1, 32'd0);
    rs2 = 5'd11; rd1(5'd3);
    chk("mid_q2", 32'(Q2), 32'd16);
    chk("mid_v_r3", V1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end
endmodule
